// File: rtl/conv1d_tap_mac.sv
// Sequential 1D convolution MAC: a TAPS-deep sample window is multiplied by the kernel one tap per cycle.
// Build option CONV_SAT_EN: saturate the result to DATA_W instead of wrap-around truncation.
module conv1d_tap_mac #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 2*DATA_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [DATA_W-1:0]        coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data
);
    localparam int AW   = $clog2(TAPS);
    localparam int IW   = $clog2(TAPS) + 1;
    localparam int PW   = 2*DATA_W;
    localparam int EXTW = ACC_W - PW;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state_q;
    logic [DATA_W-1:0]         win_q  [TAPS];
    logic [DATA_W-1:0]         win_d  [TAPS];
    logic [DATA_W-1:0]         coef_q [TAPS];
    logic [DATA_W-1:0]         coef_d [TAPS];
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic [IW-1:0]             idx_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [DATA_W-1:0]         out_data_q;
    logic [DATA_W-1:0]         result_d;

    logic                      accept;
    logic                      coef_wr;
    logic [AW-1:0]             tap_sel;
    logic signed [DATA_W-1:0]  tap_win;
    logic signed [DATA_W-1:0]  tap_coef;
    logic signed [PW-1:0]      tap_prod;

    assign accept  = (state_q == IDLE) && in_valid;
    // Kernel is frozen outside IDLE so a computation never sees a mixed kernel.
    assign coef_wr = (state_q == IDLE) && coef_we;

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign win_d[gi] = accept ? in_data : win_q[gi];
            end else begin : g_tail
                assign win_d[gi] = accept ? win_q[gi-1] : win_q[gi];
            end
            assign coef_d[gi] = (coef_wr && (coef_addr == AW'(gi))) ? coef_data : coef_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                win_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            win_q  <= win_d;
            coef_q <= coef_d;
        end
    end

    assign tap_sel  = idx_q[AW-1:0];
    assign tap_win  = $signed(win_q[tap_sel]);
    assign tap_coef = $signed(coef_q[tap_sel]);
    assign tap_prod = tap_win * tap_coef;
    assign acc_d    = acc_q + $signed({{EXTW{tap_prod[PW-1]}}, tap_prod});

`ifdef CONV_SAT_EN
    logic ovf_pos;
    logic ovf_neg;
    // In range only when all bits above the DATA_W sign bit match the accumulator sign.
    assign ovf_pos  = !acc_d[ACC_W-1] && (|acc_d[ACC_W-2:DATA_W-1]);
    assign ovf_neg  =  acc_d[ACC_W-1] && !(&acc_d[ACC_W-2:DATA_W-1]);
    assign result_d = ovf_pos ? {1'b0, {(DATA_W-1){1'b1}}} :
                      ovf_neg ? {1'b1, {(DATA_W-1){1'b0}}} :
                      acc_d[DATA_W-1:0];
`else
    assign result_d = acc_d[DATA_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IW'(TAPS-1)) begin
                        out_data_q  <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule
